// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter for the write port of one fifo.
// A granted requester keeps the port until it writes its last byte. A watchdog
// releases an owner that drops req mid-packet for TMO consecutive cycles.
//
// state | meaning
// IDLE  | no packet locked; arbitrate among requesters, no byte moves
// LOCK  | owner holds the fifo write port; bytes move while req[owner] & ~fifo_full
module fifo_wr_arbiter #(
    parameter int N   = 2,
    parameter int IW  = 1,
    parameter int B   = 8,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [N*B-1:0] req_data,
    output logic [N-1:0]   gnt,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_wr_data,
    input  logic           fifo_full,
    output logic           busy,
    output logic [IW-1:0]  owner,
    output logic           timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [15:0] TMO_M1 = 16'(TMO - 1);

    state_t        state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr_q;
    logic [15:0]   tmo_cnt_q;
    logic          timeout_q;

    logic [IW-1:0] scan_idx;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          own_req;
    logic          own_last;
    logic          accept;

    assign own_req  = req[owner_q];
    assign own_last = last[owner_q];
    assign accept   = (state_q == LOCK) & own_req & ~fifo_full;

    // Round-robin pick: scan from rr_ptr+1 upward; the loop runs from the farthest
    // candidate to the nearest so the nearest requesting index wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = N; k >= 1; k--) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % N);
            if (req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Write-port steering: the owner's byte is always presented, strobes only on accept.
    // Strobes are also masked by reset so a held-off lock cannot write.
    always_comb begin
        gnt          = '0;
        fifo_wr_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                gnt[i]       = accept & reset_n;
                fifo_wr_data = req_data[i*B +: B];
            end
        end
        fifo_wr = accept & reset_n;
    end

    // Lock FSM with watchdog; rr_ptr records the last owner so it drops to lowest priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= IW'(N - 1);
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q   <= pick_idx;
                        state_q   <= LOCK;
                        tmo_cnt_q <= '0;
                    end
                end
                LOCK: begin
                    if (own_req) begin
                        // A full-fifo stall keeps req high, so it never feeds the watchdog.
                        tmo_cnt_q <= '0;
                        if (accept && own_last) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= owner_q;
                        end
                    end else if (tmo_cnt_q == TMO_M1) begin
                        // Partial packet already in the fifo is left there.
                        state_q   <= IDLE;
                        rr_ptr_q  <= owner_q;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q == LOCK);
    assign owner   = owner_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with a behavioural 16-entry fifo model.
module tb_fifo_wr_arbiter;

    localparam int N   = 2;
    localparam int IW  = 1;
    localparam int B   = 8;
    localparam int TMO = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   last = '0;
    logic [N*B-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           fifo_wr;
    logic [B-1:0]   fifo_wr_data;
    logic           fifo_full;
    logic           busy;
    logic [IW-1:0]  owner;
    logic           timeout;

    logic           full_force = 1'b0;
    logic           rd = 1'b0;
    logic           fclr = 1'b0;
    logic [7:0]     fmem [0:15];
    logic [3:0]     wp = '0;
    logic [3:0]     rp = '0;
    int             cnt = 0;
    logic [7:0]     rdata;

    int checks = 0;
    int failures = 0;

    fifo_wr_arbiter #(.N(N), .IW(IW), .B(B), .TMO(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .last         (last),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .owner        (owner),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Fifo model: full updates at the write edge, reads pop at the edge.
    always @(posedge clk) begin
        if (fclr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= 0;
        end else begin
            if (fifo_wr) begin
                fmem[wp] <= fifo_wr_data;
                wp       <= wp + 4'd1;
            end
            if (rd) rp <= rp + 4'd1;
            cnt <= cnt + (fifo_wr ? 1 : 0) - (rd ? 1 : 0);
        end
    end

    assign fifo_full = full_force | (cnt >= 16);
    assign rdata     = fmem[rp];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; fclr = 1'b1; req = '0; last = '0; full_force = 1'b0; rd = 1'b0;
        tick();
        tick();
        reset_n = 1'b1; fclr = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; fclr = 1'b1; req = 2'b11; last = 2'b00;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", owner); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        #1;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", fifo_wr); end
        reset_n = 1'b1; fclr = 1'b0; req = '0;
        tick();
    endtask

    task automatic test_single_packet;
        logic [7:0] exp_b [3];
        exp_b = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        req = 2'b01; last = 2'b00; req_data[7:0] = 8'hA1;
        #1;
        checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL single_arb_wr got=%b exp=0", fifo_wr); end
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL single_arb_gnt got=%b exp=00", gnt); end
        tick();
        for (int b = 0; b < 3; b++) begin
            req_data[7:0] = exp_b[b];
            last = (b == 2) ? 2'b01 : 2'b00;
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy b=%0d got=%b exp=1", b, busy); end
            #1;
            checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt b=%0d got=%b exp=01", b, gnt); end
            checks++; if (fifo_wr_data !== exp_b[b]) begin failures++; $display("FAIL single_data b=%0d got=%h exp=%h", b, fifo_wr_data, exp_b[b]); end
            tick();
        end
        req = '0; last = '0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (cnt !== 3) begin failures++; $display("FAIL single_count got=%0d exp=3", cnt); end
        for (int b = 0; b < 3; b++) begin
            rd = 1'b1;
            #1;
            checks++; if (rdata !== exp_b[b]) begin failures++; $display("FAIL single_readback b=%0d got=%h exp=%h", b, rdata, exp_b[b]); end
            tick();
            rd = 1'b0;
        end
    endtask

    task automatic test_round_robin;
        int         bi [2];
        int         pk [2];
        int         e;
        logic [1:0] eg;
        logic [7:0] exp;
        do_reset();
        bi = '{0, 0};
        pk = '{0, 0};
        req = 2'b11;
        for (int p = 0; p < 4; p++) begin
            e  = p % 2;
            eg = (e == 0) ? 2'b01 : 2'b10;
            req_data[7:0]  = 8'(8'h10 + pk[0] * 2 + bi[0]);
            req_data[15:8] = 8'(8'h20 + pk[1] * 2 + bi[1]);
            last = {bi[1] == 1, bi[0] == 1};
            #1;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_busy p=%0d got=%b exp=0", p, busy); end
            checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL rr_idle_wr p=%0d got=%b exp=0", p, fifo_wr); end
            tick();
            for (int b = 0; b < 2; b++) begin
                req_data[7:0]  = 8'(8'h10 + pk[0] * 2 + bi[0]);
                req_data[15:8] = 8'(8'h20 + pk[1] * 2 + bi[1]);
                last = {bi[1] == 1, bi[0] == 1};
                exp = (e == 0) ? 8'(8'h10 + pk[0] * 2 + b) : 8'(8'h20 + pk[1] * 2 + b);
                #1;
                checks++; if (owner !== 1'(e)) begin failures++; $display("FAIL rr_owner p=%0d b=%0d got=%0d exp=%0d", p, b, owner, e); end
                checks++; if (gnt !== eg) begin failures++; $display("FAIL rr_gnt p=%0d b=%0d got=%b exp=%b", p, b, gnt, eg); end
                checks++; if (fifo_wr_data !== exp) begin failures++; $display("FAIL rr_data p=%0d b=%0d got=%h exp=%h", p, b, fifo_wr_data, exp); end
                tick();
                bi[e]++;
                if (bi[e] == 2) begin
                    bi[e] = 0;
                    pk[e]++;
                end
            end
        end
        req = '0; last = '0;
    endtask

    task automatic test_full_stall;
        do_reset();
        req = 2'b10; last = 2'b00; req_data[15:8] = 8'hB1;
        tick();
        #1;
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL stall_owner got=%b exp=1", owner); end
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL stall_first_gnt got=%b exp=10", gnt); end
        tick();
        full_force = 1'b1; req_data[15:8] = 8'hB2;
        for (int s = 0; s < 5; s++) begin
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL stall_timeout s=%0d got=%b exp=0", s, timeout); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy s=%0d got=%b exp=1", s, busy); end
            #1;
            checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL stall_gnt s=%0d got=%b exp=00", s, gnt); end
            checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL stall_wr s=%0d got=%b exp=0", s, fifo_wr); end
            tick();
        end
        full_force = 1'b0;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL stall_resume_timeout got=%b exp=0", timeout); end
        #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL stall_resume_gnt got=%b exp=10", gnt); end
        checks++; if (fifo_wr_data !== 8'hB2) begin failures++; $display("FAIL stall_resume_data got=%h exp=b2", fifo_wr_data); end
        tick();
        req_data[15:8] = 8'hB3; last = 2'b10;
        #1;
        checks++; if (fifo_wr_data !== 8'hB3) begin failures++; $display("FAIL stall_last_data got=%h exp=b3", fifo_wr_data); end
        tick();
        req = '0; last = '0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy_end got=%b exp=0", busy); end
        checks++; if (cnt !== 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", cnt); end
    endtask

    task automatic test_timeout;
        do_reset();
        req = 2'b01; last = 2'b00; req_data = {8'hD1, 8'hC1};
        tick();
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL tmo_first_gnt got=%b exp=01", gnt); end
        tick();
        req = 2'b10; last = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_wait_busy k=%0d got=%b exp=1", k, busy); end
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_wait_pulse k=%0d got=%b exp=0", k, timeout); end
            #1;
            checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL tmo_wait_gnt k=%0d got=%b exp=00", k, gnt); end
            tick();
        end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b exp=1", timeout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
        tick();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse_width got=%b exp=0", timeout); end
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL tmo_next_owner got=%b exp=1", owner); end
        #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL tmo_next_gnt got=%b exp=10", gnt); end
        checks++; if (fifo_wr_data !== 8'hD1) begin failures++; $display("FAIL tmo_next_data got=%h exp=d1", fifo_wr_data); end
        tick();
        req = '0; last = '0;
        checks++; if (cnt !== 2) begin failures++; $display("FAIL tmo_count got=%0d exp=2", cnt); end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        req = 2'b10; last = 2'b00; req_data = {8'hE1, 8'hF1};
        tick();
        #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rmid_e1_gnt got=%b exp=10", gnt); end
        tick();
        req_data[15:8] = 8'hE2;
        tick();
        req_data[15:8] = 8'hE3; reset_n = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rmid_forced_gnt got=%b exp=00", gnt); end
        checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL rmid_forced_wr got=%b exp=0", fifo_wr); end
        tick();
        reset_n = 1'b1; req = 2'b11; last = 2'b01;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL rmid_owner got=%b exp=0", owner); end
        #1;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rmid_arb_gnt got=%b exp=00", gnt); end
        tick();
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rmid_first_gnt got=%b exp=01", gnt); end
        checks++; if (fifo_wr_data !== 8'hF1) begin failures++; $display("FAIL rmid_first_data got=%h exp=f1", fifo_wr_data); end
        tick();
        req = '0; last = '0;
    endtask

    task automatic test_fill_full;
        logic [7:0] exp;
        do_reset();
        req = 2'b01; last = 2'b00; req_data[7:0] = 8'h80;
        tick();
        for (int b = 0; b < 16; b++) begin
            req_data[7:0] = 8'(8'h80 + b);
            #1;
            checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL fill_gnt b=%0d got=%b exp=01", b, gnt); end
            tick();
        end
        req_data[7:0] = 8'h90; last = 2'b01;
        for (int h = 0; h < 2; h++) begin
            #1;
            checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL fill_hold_gnt h=%0d got=%b exp=00", h, gnt); end
            checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL fill_hold_wr h=%0d got=%b exp=0", h, fifo_wr); end
            tick();
        end
        checks++; if (cnt !== 16) begin failures++; $display("FAIL fill_count_full got=%0d exp=16", cnt); end
        rd = 1'b1;
        #1;
        checks++; if (rdata !== 8'h80) begin failures++; $display("FAIL fill_read0 got=%h exp=80", rdata); end
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL fill_read_gnt got=%b exp=00", gnt); end
        tick();
        rd = 1'b0;
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL fill_17_gnt got=%b exp=01", gnt); end
        checks++; if (fifo_wr_data !== 8'h90) begin failures++; $display("FAIL fill_17_data got=%h exp=90", fifo_wr_data); end
        tick();
        req = '0; last = '0;
        checks++; if (cnt !== 16) begin failures++; $display("FAIL fill_count_after got=%0d exp=16", cnt); end
        for (int k = 1; k <= 16; k++) begin
            exp = (k < 16) ? 8'(8'h80 + k) : 8'h90;
            rd = 1'b1;
            #1;
            checks++; if (rdata !== exp) begin failures++; $display("FAIL fill_drain k=%0d got=%h exp=%h", k, rdata, exp); end
            tick();
            rd = 1'b0;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL fill_count_empty got=%0d exp=0", cnt); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_timeout();
        test_reset_mid_packet();
        test_fill_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit got=expired exp=finish");
        $fatal(1);
    end

endmodule
